// File: rtl/clk_gen_pkg.sv
// Shared definitions for the CPU clock generator: mode encodings,
// the divisor floor and the divider FSM states.
package clk_gen_pkg;

  localparam logic [1:0] MODE_FAST = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_PROG = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    STEP_IDLE  = 2'b01,
    STEP_PULSE = 2'b10
  } div_state_e;

endpackage

// File: rtl/clk_gen_step_debounce.sv
// Step push-button conditioner: two-flop synchroniser, stable-level
// counter, and a one-cycle press pulse on each accepted rising level.
module step_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: non-blocking here so sync1 -> sync2 forms a real two-stage pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // Enough consecutive disagreeing samples: adopt the new level.
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_gen.sv
// CPU clock generator: free-running scan counter, registered CPU clock and
// tick, four modes with changes applied only at a CPU-clock period boundary.
module clk_gen
  import clk_gen_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          DIV_W      = 32,
  parameter int unsigned FAST_DIV   = 4,
  parameter int unsigned SLOW_DIV   = 33554432,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             step_btn,
  output logic [CNT_W-1:0] clkdiv,
  output logic             cpu_clk,
  output logic             cpu_tick,
  output logic [1:0]       act_mode,
  output logic [31:0]      cpu_cycles
);

  div_state_e       state;
  div_state_e       state_next;
  logic [DIV_W-1:0] pcnt;
  logic [DIV_W-1:0] pcnt_next;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] act_div_next;
  logic [DIV_W-1:0] prog_div;
  logic [DIV_W-1:0] n_req;
  logic [DIV_W-1:0] end_m1;
  logic [DIV_W-1:0] half_m1;
  logic [1:0]       act_mode_next;
  logic             at_end;
  logic             tick_d;
  logic             clk_d;
  logic             press;

  step_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(step_btn),
    .press  (press)
  );

  assign end_m1  = act_div - DIV_W'(1);
  assign half_m1 = (act_div >> 1) - DIV_W'(1);
  assign at_end  = (pcnt == end_m1);

  // STEP keeps the current divisor; it is reloaded on exit anyway.
  always_comb begin
    case (mode)
      MODE_FAST: n_req = DIV_W'(FAST_DIV);
      MODE_SLOW: n_req = DIV_W'(SLOW_DIV);
      MODE_PROG: n_req = prog_div;
      default:   n_req = act_div;
    endcase
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    pcnt_next     = pcnt;
    act_mode_next = act_mode;
    act_div_next  = act_div;
    case (state)
      RUN: begin
        if (at_end) begin
          pcnt_next     = '0;
          act_mode_next = mode;
          act_div_next  = n_req;
          state_next    = (mode == MODE_STEP) ? STEP_IDLE : RUN;
        end else begin
          pcnt_next = pcnt + DIV_W'(1);
        end
      end
      default: begin
        pcnt_next = '0;
        // Leaving STEP wins over a coincident press, which is dropped.
        if (mode != MODE_STEP) begin
          act_mode_next = mode;
          act_div_next  = n_req;
          state_next    = RUN;
        end else begin
          state_next = press ? STEP_PULSE : STEP_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    tick_d = 1'b0;
    clk_d  = cpu_clk;
    if (state == RUN) begin
      tick_d = at_end;
      if (at_end) begin
        clk_d = 1'b1;
      end else if (pcnt == half_m1) begin
        clk_d = 1'b0;
      end
    end else begin
      tick_d = (state_next == STEP_PULSE);
      clk_d  = tick_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pcnt       <= '0;
      act_mode   <= MODE_FAST;
      act_div    <= DIV_W'(FAST_DIV);
      prog_div   <= DIV_W'(FAST_DIV);
      clkdiv     <= '0;
      cpu_clk    <= 1'b0;
      cpu_tick   <= 1'b0;
      cpu_cycles <= '0;
    end else begin
      state      <= state_next;
      pcnt       <= pcnt_next;
      act_mode   <= act_mode_next;
      act_div    <= act_div_next;
      clkdiv     <= clkdiv + CNT_W'(1);
      cpu_clk    <= clk_d;
      cpu_tick   <= tick_d;
      cpu_cycles <= cpu_cycles + 32'(tick_d);
      if (div_load) begin
        prog_div <= (div_value < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_value;
      end
    end
  end

endmodule

// File: tb/tb_clk_gen.sv
// Self-checking bench for clk_gen: a period-level reference model compared
// every cycle, plus hand-computed checks of the key timing scenarios.
module tb_clk_gen;

  localparam int CNT_W = 32;
  localparam int DIV_W = 32;
  localparam int FAST  = 4;
  localparam int SLOW  = 10;
  localparam int DEB   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             step_btn = 1'b0;
  logic [CNT_W-1:0] clkdiv;
  logic             cpu_clk;
  logic             cpu_tick;
  logic [1:0]       act_mode;
  logic [31:0]      cpu_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clk_gen #(
    .CNT_W     (CNT_W),
    .DIV_W     (DIV_W),
    .FAST_DIV  (FAST),
    .SLOW_DIV  (SLOW),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .div_load  (div_load),
    .div_value (div_value),
    .step_btn  (step_btn),
    .clkdiv    (clkdiv),
    .cpu_clk   (cpu_clk),
    .cpu_tick  (cpu_tick),
    .act_mode  (act_mode),
    .cpu_cycles(cpu_cycles)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the current CPU period and the
  // button history, and derives outputs from the period rules directly.
  int unsigned m_mode, m_n, m_k, m_prog;
  bit          m_prev_high, m_press_d, m_level, m_tick, m_clk;
  bit [31:0]   m_clkdiv, m_cycles;
  bit          hist [0:DEB+1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_n = FAST; m_k = 0; m_prog = FAST;
      m_prev_high = 0; m_press_d = 0; m_level = 0; m_tick = 0; m_clk = 0;
      m_clkdiv = 0; m_cycles = 0;
      for (int i = 0; i < DEB + 2; i++) hist[i] = 0;
    end else begin
      int unsigned nreq;
      bit          evt, all_diff;
      m_clkdiv = m_clkdiv + 1;
      evt = m_press_d;
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = step_btn;
      all_diff = 1;
      for (int i = 2; i < DEB + 2; i++) if (hist[i] == m_level) all_diff = 0;
      m_press_d = 0;
      if (all_diff) begin
        m_level   = ~m_level;
        m_press_d = m_level;
      end
      case (mode)
        2'b00:   nreq = FAST;
        2'b01:   nreq = SLOW;
        2'b10:   nreq = m_prog;
        default: nreq = m_n;
      endcase
      if (div_load) m_prog = (div_value < 2) ? 2 : div_value;
      if (m_mode != 3) begin
        m_k++;
        m_tick = (m_k == m_n);
        m_clk  = m_tick || (m_prev_high && m_k < m_n / 2);
        if (m_tick) begin
          m_k = 0; m_prev_high = 1; m_mode = mode; m_n = nreq;
        end
      end else if (mode != 2'b11) begin
        m_mode = mode; m_n = nreq; m_k = 0; m_prev_high = 0; m_tick = 0; m_clk = 0;
      end else begin
        m_tick = evt;
        m_clk  = evt;
      end
      if (m_tick) m_cycles = m_cycles + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      check("cmp_cpu_clk", cpu_clk, m_clk);
      check("cmp_cpu_tick", cpu_tick, m_tick);
      check("cmp_act_mode", act_mode, m_mode);
      check("cmp_cpu_cycles", cpu_cycles, m_cycles);
      check("cmp_clkdiv", clkdiv, m_clkdiv);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Waits for a tick, then reports cycles to the next tick and high cycles in between.
  task automatic measure(input string name, output int per, output int hi);
    int guard;
    per = 0; hi = 0; guard = 0;
    @(negedge clk);
    while (!cpu_tick && guard < 60) begin @(negedge clk); guard++; end
    if (guard >= 60) begin check({name, "_timeout"}, 1'b1, 1'b0); return; end
    do begin
      hi += int'(cpu_clk);
      per++;
      @(negedge clk);
    end while (!cpu_tick && per < 60);
  endtask

  task automatic wait_mode(input string name, input logic [1:0] exp);
    int guard = 0;
    while (act_mode != exp && guard < 30) begin @(negedge clk); guard++; end
    check(name, act_mode, exp);
  endtask

  initial begin
    int per, hi, cnt, first, c0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_clkdiv", clkdiv, 0);
    check("rst_cpu_clk", cpu_clk, 0);
    check("rst_cpu_tick", cpu_tick, 0);
    check("rst_act_mode", act_mode, 0);
    check("rst_cpu_cycles", cpu_cycles, 0);
    reset = 1'b0;

    // FAST: tick every 4th edge, cpu_clk 1100 from edge 4
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("fast_tick", cpu_tick, (k % 4) == 0);
      check("fast_clk", cpu_clk, k >= 4 && ((k % 4) == 0 || (k % 4) == 1));
    end
    check("fast_cycles12", cpu_cycles, 3);
    check("fast_clkdiv12", clkdiv, 12);

    // FAST -> SLOW requested at pcnt=1
    @(negedge clk);
    mode = 2'b01;
    repeat (2) @(negedge clk);
    check("slow_pending_mode", act_mode, 2'b00);
    measure("slow", per, hi);
    check("slow_period", per, 10);
    check("slow_high", hi, 5);
    check("slow_act_mode", act_mode, 2'b01);

    // PROG with divisor 5
    div_load = 1'b1; div_value = 5; mode = 2'b10;
    @(negedge clk);
    div_load = 1'b0;
    measure("prog5", per, hi);
    check("prog5_period", per, 5);
    check("prog5_high", hi, 2);
    check("prog5_act_mode", act_mode, 2'b10);

    // div_value 0 clamps to 2
    div_load = 1'b1; div_value = 0;
    @(negedge clk);
    div_load = 1'b0;
    measure("prog2", per, hi);
    check("prog2_period", per, 2);
    check("prog2_high", hi, 1);

    // STEP: bounce then a stable press gives exactly one pulse
    mode = 2'b11;
    wait_mode("step_enter", 2'b11);
    repeat (3) @(negedge clk);
    c0 = cpu_cycles;
    step_btn = 1'b1; repeat (3) @(negedge clk);
    step_btn = 1'b0; repeat (3) @(negedge clk);
    check("bounce_no_pulse", cpu_cycles, c0);
    step_btn = 1'b1;
    cnt = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_tick) begin cnt++; if (first == 0) first = i; end
      check("step_clk_eq_tick", cpu_clk, cpu_tick);
    end
    check("step_pulse_count", cnt, 1);
    check("step_pulse_latency", first, 11);
    check("step_cycles", cpu_cycles, c0 + 1);
    step_btn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); cnt += int'(cpu_tick); end
    check("step_release_no_pulse", cnt, 0);

    // Press in FAST is discarded; entering STEP afterwards gives no stale pulse
    mode = 2'b00;
    wait_mode("step_exit_fast", 2'b00);
    c0 = cpu_cycles;
    step_btn = 1'b1;
    repeat (16) @(negedge clk);
    check("fast_press_ignored", cpu_cycles - c0, 4);
    mode = 2'b11;
    wait_mode("step_reenter", 2'b11);
    c0 = cpu_cycles;
    repeat (12) @(negedge clk);
    check("no_stale_pulse", cpu_cycles, c0);

    // STEP -> SLOW: first tick after 10 cycles
    mode = 2'b01;
    @(negedge clk);
    check("step_exit_slow", act_mode, 2'b01);
    first = 1;
    while (!cpu_tick && first < 40) begin @(negedge clk); first++; end
    check("step_exit_first_tick", first, 11);

    // Reset at pcnt=2 in SLOW
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_cpu_clk", cpu_clk, 0);
    check("midrst_cpu_tick", cpu_tick, 0);
    check("midrst_act_mode", act_mode, 0);
    check("midrst_cycles", cpu_cycles, 0);
    check("midrst_clkdiv", clkdiv, 0);
    @(negedge clk);
    reset = 1'b0;
    first = 0;
    do begin @(negedge clk); first++; end while (!cpu_tick && first < 40);
    check("postrst_first_tick", first, 4);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gen.md
Name: clk_gen

Overview:
- Parametrised CPU clock generator for the multi-cycle CPU; successor to the fixed two-speed divider.
- Produces a free-running divide counter for display scanning, plus a registered CPU clock and a one-cycle tick enable.
- Supports four modes: fast, slow, programmable divisor, and debounced single-step.
- Speed and mode changes are glitch-free: they take effect only at a CPU-clock period boundary.

Parameters:
- CNT_W, 32, width of the free-running clkdiv counter
- DIV_W, 32, width of divisors and the period counter
- FAST_DIV, 4, fast-mode period in clk cycles (at least 2)
- SLOW_DIV, 33554432, slow-mode period in clk cycles (at least 2)
- DEB_CYCLES, 1000000, consecutive stable samples required to accept a step-button level

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- mode  in  2  requested mode: 00 FAST, 01 SLOW, 10 PROG, 11 STEP
- div_load  in  1  load div_value into the programmable divisor register
- div_value  in  DIV_W  programmable divisor
- step_btn  in  1  raw, asynchronous step push-button
- clkdiv  out  CNT_W  free-running counter
- cpu_clk  out  1  registered CPU clock
- cpu_tick  out  1  one-cycle pulse, coincident with each cpu_clk rising period
- act_mode  out  2  currently active mode
- cpu_cycles  out  32  count of cpu_tick pulses

Behaviour:
- Clock and reset: clock clk; reset is asynchronous, active-high. All state clears on reset, including mid-period and mid-debounce.
- Reset values: clkdiv=0, pcnt=0, cpu_clk=0, cpu_tick=0, act_mode=00 (FAST), act_div=FAST_DIV, prog_div=FAST_DIV, cpu_cycles=0, debouncer cleared.
- clkdiv: increments every clk; wraps to 0 from all-ones.
- Divisor clamp: prog_div <= (div_value<2) ? 2 : div_value when div_load=1. The load is accepted in any mode.
- Requested divisor N_req by mode: FAST=FAST_DIV, SLOW=SLOW_DIV, PROG=prog_div.
- Run modes (act_mode != STEP), N=act_div:
  - pcnt <= (pcnt==N-1) ? 0 : pcnt+1.
  - cpu_tick <= (pcnt==N-1).
  - cpu_clk <= 1 when pcnt==N-1; cpu_clk <= 0 when pcnt==N/2-1 (floor division).
  - Result: cpu_clk is high for floor(N/2) cycles and low for the remainder.
  - First tick after reset release appears on the N-th rising edge.
- Boundary update: at pcnt==N-1 the block loads act_mode<=mode and act_div<=N_req for the new mode.
  - The tick for the completing period is still issued; the new N applies from the next period.
  - No mid-period truncation or extension.
  - A div_load during PROG applies at the next boundary.
- STEP mode (act_mode==STEP):
  - pcnt is held at 0.
  - Each debounced press event sets cpu_tick=1 and cpu_clk=1 for exactly the next cycle, then both return to 0.
  - A mode change to a run mode takes effect on the next cycle with pcnt=0 (first tick after N cycles).
  - A press event arriving in the same cycle as the exit from STEP is dropped.
- Press events while not in STEP are discarded; they are never queued.
- cpu_cycles increments by 1 on every cpu_tick and wraps at 2^32.
- Debouncer (sub-module):
  - Two-flop synchroniser feeding a stable-level counter.
  - The accepted level changes only after DEB_CYCLES consecutive samples differing from it.
  - Emits a one-cycle press pulse on each accepted 0->1 transition; bounces shorter than DEB_CYCLES produce nothing.

Decomposition:
- Shared package holds:
  - mode encodings MODE_FAST=2'b00, MODE_SLOW=2'b01, MODE_PROG=2'b10, MODE_STEP=2'b11
  - minimum divisor constant DIV_MIN=2
- Sub-module step_debounce (params DEB_CYCLES; ports clk, reset, btn_raw, press).
- clk_gen contains:
  - divider FSM states RUN and STEP_IDLE, plus a STEP_PULSE single-cycle state
  - counters
  - prog_div register

Test Plan:
- Run with FAST_DIV=4, SLOW_DIV=10, DEB_CYCLES=8 unless stated.
- Reset release, mode=00 -> first cpu_tick at edge 4, then every 4 cycles; cpu_clk pattern 1100 repeating; cpu_cycles=3 after 12 cycles; clkdiv=12.
- Switch mode 00->01 at pcnt=1 -> current 4-cycle period completes with its tick; next period is 10 cycles with cpu_clk high 5, low 5; act_mode=01 only after the boundary.
- div_load with div_value=5, then mode=10 -> periods of 5 with cpu_clk high 2, low 3; separately, div_value=0 loads as 2 -> cpu_clk toggles every cycle.
- Mode=11, step_btn bounces 3 cycles, then holds high 8+ cycles -> exactly one cpu_tick/cpu_clk pulse about 10 cycles after the stable rise; cpu_cycles +1; no pulse from the bounces.
- Press step_btn while in mode 00 -> no extra tick; then switch to 11 -> no stale pulse is generated.
- Assert reset mid-period (pcnt=2, SLOW) -> all outputs 0 immediately; act_mode=00; after release, first tick at edge 4.
